uart_tx_arbiter: RTL and testbench

Shares one uart_tx_controller between NUM_REQ byte requesters using round-robin arbitration.
- Latches the granted requester's byte and drives the transmitter's ready/byte inputs.
- Tracks the transmitter's active/done status through 2-flop synchronizers and reports per-requester completion.
- A watchdog recovers the arbiter if the transmitter never completes.
- Sits between client logic and the uart_tx_controller instance inside the top-level uartController.

---
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte requesters.
// Tracks the transmitter's async status flags and aborts stuck transfers.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
  output logic [NUM_REQ-1:0]         o_Req_Ack,
  output logic [NUM_REQ-1:0]         o_Req_Done,
  output logic                       o_Tx_Ready,
  output logic [7:0]                 o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
  output logic                       o_Busy,
  output logic                       o_Timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, LAUNCH, WAIT_DONE, COMPLETE
  } state_e;

  state_e state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tmo_q, tmo_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic act_m_q, act_s_q;
  logic done_m_q, done_s_q, done_p_q;

  logic          done_rise;
  logic          wd_hit;
  logic          pick_vld;
  logic [IW-1:0] pick_id;
  logic [7:0]    pick_byte;
  logic [IW-1:0] cand;
  int            idx;

  assign done_rise = done_s_q & ~done_p_q;
  assign wd_hit    = (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      grant_q  <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      ack_q    <= '0;
      tmo_q    <= 1'b0;
      wd_q     <= '0;
      act_m_q  <= 1'b0;
      act_s_q  <= 1'b0;
      done_m_q <= 1'b0;
      done_s_q <= 1'b0;
      done_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      tmo_q    <= tmo_d;
      wd_q     <= wd_d;
      act_m_q  <= i_Tx_Active;
      act_s_q  <= act_m_q;
      done_m_q <= i_Tx_Done;
      done_s_q <= done_m_q;
      done_p_q <= done_s_q;
    end
  end

  // Search upward from the requester after the last grant, wrapping.
  always_comb begin
    pick_vld  = 1'b0;
    pick_id   = '0;
    pick_byte = '0;
    cand      = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!pick_vld && i_Req[cand]) begin
        pick_vld  = 1'b1;
        pick_id   = cand;
        pick_byte = i_Req_Byte[8*idx +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = '0;
    tmo_d   = 1'b0;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LAUNCH;
          byte_d  = pick_byte;
          grant_d = pick_id;
          ack_d   = ONE << pick_id;
          wd_d    = '0;
        end
      end
      LAUNCH, WAIT_DONE: begin
        wd_d = wd_q + 1'b1;
        // Completion beats the watchdog, which beats the active handoff.
        if (done_rise) begin
          state_d = COMPLETE;
        end else if (wd_hit) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          last_d  = grant_q;
        end else if (state_q == LAUNCH && act_s_q) begin
          state_d = WAIT_DONE;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_Req_Ack  = ack_q;
    o_Req_Done = (state_q == COMPLETE) ? (ONE << grant_q) : '0;
    o_Tx_Ready = (state_q == LAUNCH);
    o_Tx_Byte  = byte_q;
    o_Grant_Id = grant_q;
    o_Busy     = (state_q != IDLE);
    o_Timeout  = tmo_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with a scoreboard
// of expected ack/done/timeout events checked by a separate monitor.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  i_Req = '0;
  logic [31:0] i_Req_Byte = '0;
  logic [3:0]  o_Req_Ack;
  logic [3:0]  o_Req_Done;
  logic        o_Tx_Ready;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Active = 1'b0;
  logic        i_Tx_Done = 1'b0;
  logic [1:0]  o_Grant_Id;
  logic        o_Busy;
  logic        o_Timeout;

  int checks = 0;
  int fails = 0;

  typedef struct {
    int         kind;
    logic [3:0] vec;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_Req(i_Req),
    .i_Req_Byte(i_Req_Byte),
    .o_Req_Ack(o_Req_Ack),
    .o_Req_Done(o_Req_Done),
    .o_Tx_Ready(o_Tx_Ready),
    .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Active(i_Tx_Active),
    .i_Tx_Done(i_Tx_Done),
    .o_Grant_Id(o_Grant_Id),
    .o_Busy(o_Busy),
    .o_Timeout(o_Timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic void push_ack(int id, logic [7:0] b);
    exp_t e;
    e.kind = 0;
    e.vec  = 4'(1 << id);
    e.data = b;
    q.push_back(e);
  endfunction

  function automatic void push_done(int id);
    exp_t e;
    e.kind = 1;
    e.vec  = 4'(1 << id);
    e.data = 8'h00;
    q.push_back(e);
  endfunction

  function automatic void push_tmo();
    exp_t e;
    e.kind = 2;
    e.vec  = 4'h0;
    e.data = 8'h00;
    q.push_back(e);
  endfunction

  task automatic check_evt(int k, logic [3:0] v, logic [7:0] d);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL evt_unexpected: got kind=%0d vec=%b, required no event",
               k, v);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.vec != v || (k == 0 && e.data != d)) begin
        fails++;
        $display("FAIL evt: got kind=%0d vec=%b byte=%h, required kind=%0d vec=%b byte=%h",
                 k, v, d, e.kind, e.vec, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_Req_Ack != 4'h0) check_evt(0, o_Req_Ack, o_Tx_Byte);
      if (o_Req_Done != 4'h0) check_evt(1, o_Req_Done, 8'h00);
      if (o_Timeout) check_evt(2, 4'h0, 8'h00);
    end
  end

  task automatic chk_zero(string name);
    chk({name, "_ack"}, o_Req_Ack, 0);
    chk({name, "_done"}, o_Req_Done, 0);
    chk({name, "_ready"}, o_Tx_Ready, 0);
    chk({name, "_byte"}, o_Tx_Byte, 0);
    chk({name, "_gid"}, o_Grant_Id, 0);
    chk({name, "_busy"}, o_Busy, 0);
    chk({name, "_tmo"}, o_Timeout, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    i_Req = '0;
    i_Tx_Active = 1'b0;
    i_Tx_Done = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_zero("rst");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_Tx_Ready && n < 40);
    chk("ready_wait", o_Tx_Ready, 1);
  endtask

  task automatic finish_tx(bit use_act);
    int n = 0;
    @(posedge clk);
    #1;
    if (use_act) begin
      i_Tx_Active = 1'b1;
      do begin
        @(negedge clk);
        n++;
      end while (o_Tx_Ready && n < 20);
      chk("ready_drop", o_Tx_Ready, 0);
      @(posedge clk);
      #1;
    end
    i_Tx_Done = 1'b1;
    @(posedge clk);
    #1;
    i_Tx_Done = 1'b0;
    i_Tx_Active = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_Busy && n < 20);
    chk("idle_wait", o_Busy, 0);
  endtask

  initial begin
    int n;

    // 1: single request from requester 1
    do_reset();
    push_ack(1, 8'hA5);
    push_done(1);
    @(posedge clk);
    #1;
    i_Req_Byte[15:8] = 8'hA5;
    i_Req = 4'b0010;
    @(negedge clk);
    chk("t1_pre_ack", o_Req_Ack, 0);
    @(negedge clk);
    chk("t1_ack", o_Req_Ack, 4'b0010);
    chk("t1_byte", o_Tx_Byte, 8'hA5);
    chk("t1_ready", o_Tx_Ready, 1);
    chk("t1_gid", o_Grant_Id, 1);
    chk("t1_busy", o_Busy, 1);
    i_Req = 4'b0000;
    @(posedge clk);
    #1;
    i_Tx_Active = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (o_Tx_Ready && n < 10);
    chk("t1_ready_lat_ok", (n >= 2 && n <= 3), 1);
    i_Tx_Done = 1'b1;
    i_Tx_Active = 1'b0;
    @(posedge clk);
    #1;
    i_Tx_Done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t1_done", o_Req_Done, 4'b0010);
    chk("t1_busy_cmpl", o_Busy, 1);
    @(posedge clk);
    #1;
    chk("t1_done_end", o_Req_Done, 0);
    chk("t1_busy_end", o_Busy, 0);
    chk("t1_byte_hold", o_Tx_Byte, 8'hA5);

    // 2: fairness with all four requesting
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_ack(i % 4, 8'h10 + 8'(i % 4) * 8'h11);
      push_done(i % 4);
    end
    @(posedge clk);
    #1;
    i_Req_Byte = 32'h43_32_21_10;
    i_Req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ready();
      if (i == 4) i_Req = 4'b0000;
      finish_tx(1'b1);
    end

    // 3: alternation between requesters 0 and 2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_ack((i % 2) * 2, (i % 2 == 0) ? 8'h0F : 8'hF2);
      push_done((i % 2) * 2);
    end
    @(posedge clk);
    #1;
    i_Req_Byte = 32'h00_F2_00_0F;
    i_Req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      if (i == 3) i_Req = 4'b0000;
      finish_tx(1'b1);
    end

    // 4: watchdog abort, then the next pending requester
    do_reset();
    push_ack(0, 8'h11);
    push_tmo();
    push_ack(1, 8'h22);
    push_done(1);
    @(posedge clk);
    #1;
    i_Req_Byte = 32'h00_00_22_11;
    i_Req = 4'b0011;
    wait_ready();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_Timeout && n < 40);
    chk("t4_tmo_lat", n, 16);
    chk("t4_busy", o_Busy, 0);
    chk("t4_ready", o_Tx_Ready, 0);
    chk("t4_nodone", o_Req_Done, 0);
    wait_ready();
    chk("t4_gid", o_Grant_Id, 1);
    i_Req = 4'b0000;
    finish_tx(1'b1);

    // 5: done seen while still launching
    do_reset();
    push_ack(2, 8'h5A);
    push_done(2);
    @(posedge clk);
    #1;
    i_Req_Byte = 32'h00_5A_00_00;
    i_Req = 4'b0100;
    wait_ready();
    i_Req = 4'b0000;
    @(posedge clk);
    #1;
    i_Tx_Done = 1'b1;
    @(posedge clk);
    #1;
    i_Tx_Done = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_ready_launch", o_Tx_Ready, 1);
    @(posedge clk);
    #1;
    chk("t5_done", o_Req_Done, 4'b0100);
    chk("t5_ready_cmpl", o_Tx_Ready, 0);
    @(posedge clk);
    #1;
    chk("t5_busy_end", o_Busy, 0);

    // 6: reset during WAIT_DONE, then a fresh grant to requester 3
    do_reset();
    push_ack(0, 8'h3C);
    @(posedge clk);
    #1;
    i_Req_Byte = 32'hC3_00_00_3C;
    i_Req = 4'b0001;
    wait_ready();
    i_Req = 4'b0000;
    @(posedge clk);
    #1;
    i_Tx_Active = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_Tx_Ready && n < 20);
    chk("t6_wait_done", o_Busy, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    i_Tx_Active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_ack(3, 8'hC3);
    push_done(3);
    i_Req = 4'b1000;
    wait_ready();
    chk("t6_ack", o_Req_Ack, 4'b1000);
    chk("t6_byte", o_Tx_Byte, 8'hC3);
    i_Req = 4'b0000;
    finish_tx(1'b1);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
